// File: rtl/lmsm_sequencer.sv
// Expands one LM/SM instruction into single-register memory micro-ops, one per
// cycle, stalling IF/ID while the sequence is in flight.
module lmsm_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int NREG      = 8,
  parameter int ADDR_STEP = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_in,
  input  logic                    is_sm_in,
  input  logic [NREG-1:0]         mask_in,
  input  logic [ADDR_W-1:0]       base_in,
  input  logic                    hold_in,
  input  logic                    flush_in,
  output logic                    stall_req_out,
  output logic                    busy_out,
  output logic                    uop_valid_out,
  output logic [$clog2(NREG)-1:0] uop_reg_out,
  output logic [ADDR_W-1:0]       uop_addr_out,
  output logic                    uop_mem_rd_out,
  output logic                    uop_mem_wr_out,
  output logic                    uop_rf_we_out,
  output logic                    uop_last_out,
  output logic                    done_out,
  output logic                    state_dbg_out
);
  localparam int RW = $clog2(NREG);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Micro-op handshake: a micro-op is presented while uop_valid_out=1 and is
  // consumed at a clock edge where hold_in=0; until then every uop_* output is frozen.
  state_t              r_state, w_state_nxt;
  logic [NREG-1:0]     r_mask_rem;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_is_sm;
  logic                r_uop_valid;
  logic [RW-1:0]       r_uop_reg;
  logic [ADDR_W-1:0]   r_uop_addr;
  logic                r_uop_last;
  logic                r_done;

  logic [NREG-1:0]     w_mask_rev;
  logic [NREG-1:0]     w_mask_next;
  logic [RW-1:0]       w_sel_idx;
  logic                w_found;
  logic                w_consumed;
  logic                w_emit;
  logic                w_accept;
  logic                w_last;

  // Instruction mask is MSB-first (bit 7 = R0); internal mask is R-index ordered.
  always_comb begin
    w_mask_rev = '0;
    for (int i = 0; i < NREG; i++) begin
      w_mask_rev[i] = mask_in[NREG-1-i];
    end
  end

  always_comb begin
    w_sel_idx = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (!w_found && r_mask_rem[i]) begin
        w_sel_idx = RW'(i);
        w_found   = 1'b1;
      end
    end
  end

  assign w_mask_next = r_mask_rem & ~(NREG'(1) << w_sel_idx);
  assign w_last      = (w_mask_next == '0);
  assign busy_out    = (r_state != IDLE) || r_uop_valid;
  assign w_consumed  = r_uop_valid && !hold_in;
  assign w_emit      = (r_state == RUN) && (!r_uop_valid || w_consumed);
  assign w_accept    = (r_state == IDLE) && !busy_out && start_in && !flush_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_in) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept && (w_mask_rev != '0)) w_state_nxt = RUN;
        RUN:     if (w_emit && w_last) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask_rem  <= '0;
      r_addr      <= '0;
      r_is_sm     <= 1'b0;
      r_uop_valid <= 1'b0;
      r_uop_reg   <= '0;
      r_uop_addr  <= '0;
      r_uop_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush_in) begin
        r_mask_rem  <= '0;
        r_uop_valid <= 1'b0;
        r_uop_last  <= 1'b0;
      end else if (w_accept) begin
        r_mask_rem <= w_mask_rev;
        r_addr     <= base_in;
        r_is_sm    <= is_sm_in;
        r_done     <= (w_mask_rev == '0);
      end else if (w_emit) begin
        r_uop_valid <= 1'b1;
        r_uop_reg   <= w_sel_idx;
        r_uop_addr  <= r_addr;
        r_uop_last  <= w_last;
        r_addr      <= r_addr + ADDR_W'(ADDR_STEP);
        r_mask_rem  <= w_mask_next;
      end else if (w_consumed) begin
        // Only the final micro-op can be consumed outside RUN.
        r_uop_valid <= 1'b0;
        r_uop_last  <= 1'b0;
        r_done      <= r_uop_last;
      end
    end
  end

  assign stall_req_out  = start_in || busy_out;
  assign uop_valid_out  = r_uop_valid;
  assign uop_reg_out    = r_uop_reg;
  assign uop_addr_out   = r_uop_addr;
  assign uop_mem_rd_out = r_uop_valid && !r_is_sm;
  assign uop_mem_wr_out = r_uop_valid && r_is_sm;
  assign uop_rf_we_out  = r_uop_valid && !r_is_sm;
  assign uop_last_out   = r_uop_valid && r_uop_last;
  assign done_out       = r_done;
  assign state_dbg_out  = r_state;
endmodule

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
Multi-cycle controller that expands one LM (load multiple) or SM (store multiple) instruction into a stream of single-register memory micro-ops for the EX/MEM datapath.
- Sits between ID and the RF/EX pipe register and stalls fetch/decode while active.
- Each micro-op carries the effective address (base + 2·k), the register index, and gated RF/MEM enables.
- Micro-ops use ALU_PASS of the address, so EX needs no change.
- A taken redirect from EX aborts the sequence.

Parameters:
ADDR_W, 16, address/data width
NREG, 8, register count; mask width; register index width is clog2(NREG)
ADDR_STEP, 2, byte increment between consecutive transfers

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start_in  in  1  ID presents a valid LM/SM this cycle
is_sm_in  in  1  1 = SM (store), 0 = LM (load)
mask_in  in  8  imm[7:0]; bit 7 ↔ R0 … bit 0 ↔ R7
base_in  in  ADDR_W  forwarded RA value at issue
hold_in  in  1  downstream stall; the presented micro-op is not consumed
flush_in  in  1  EX redirect_en; abort
stall_req_out  out  1  combinational: start_in | busy_out; stalls IF/ID
busy_out  out  1  state != IDLE or uop_valid_out
uop_valid_out  out  1  micro-op valid
uop_reg_out  out  3  LM: rf_waddr; SM: store-data source register
uop_addr_out  out  ADDR_W  memory address
uop_mem_rd_out  out  1  uop_valid_out & ~is_sm
uop_mem_wr_out  out  1  uop_valid_out & is_sm
uop_rf_we_out  out  1  uop_valid_out & ~is_sm
uop_last_out  out  1  final micro-op of the instruction
done_out  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst=1): state=IDLE; mask_rem=0; addr=0; every output 0 except stall_req_out, which follows start_in.
- States: IDLE, RUN.
- Internal registers: mask_rem[7:0] (remaining registers, R0-ordered), addr, is_sm_q.
- "Consumed" means uop_valid_out & ~hold_in at a clock edge.
- Accept: in IDLE with ~busy_out & start_in & ~flush_in:
  - latch mask (bit-reversed into R-index order), base_in→addr, is_sm_in→is_sm_q.
  - mask≠0 → RUN.
  - mask=0 → stay IDLE, no micro-ops; done_out=1 the next cycle.
- start_in while busy_out=1 is ignored; ID remains stalled via stall_req_out.
- Emit (RUN, when ~uop_valid_out or consumed):
  - select the lowest set register index i in mask_rem.
  - register uop_reg_out=i, uop_addr_out=addr, uop_valid_out=1.
  - clear bit i; addr ← addr+ADDR_STEP.
  - uop_last_out=1 if no bits remain, then state→IDLE.
- Latency: first micro-op valid 1 cycle after the accept edge. With hold_in=0, one micro-op per cycle; N set bits → N consecutive valid cycles.
- Hold: while hold_in=1 and uop_valid_out=1, all uop_* outputs stay stable and nothing advances.
- Last micro-op consumed in IDLE → uop_valid_out=0 and done_out=1 for exactly one cycle after the consuming edge.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFE+2 → 0x0000, with no flag.
- Address is sequential over transferred registers only; skipped mask bits do not advance it.
- LM with RA in the mask: the latched base is used throughout. Loading RA does not alter subsequent addresses.
- Flush (synchronous, highest priority over start, hold and emit):
  - state→IDLE; uop_valid_out=0; mask_rem=0.
  - no done_out.
  - A start_in in the same cycle is dropped.
- Reset mid-sequence: immediate return to reset values; no done_out.
- The pass-through enables are never asserted while uop_valid_out=0.

Test Plan:
- LM, mask=0xA0 (R0,R2), base=0x1000, hold=0 → uop (R0,0x1000,rd,we), then (R2,0x1002,rd,we,last); done_out pulse next cycle; stall_req_out high from the start cycle through the last-uop cycle.
- SM, mask=0xFF, base=0x0100 → 8 consecutive uops R0..R7 at 0x0100..0x010E, mem_wr=1 and rf_we=0 on all; last only on R7.
- LM, mask=0x81, base=0x2000, hold_in=1 for 3 cycles on the first uop → (R0,0x2000) held stable for 4 cycles, then (R7,0x2002,last); exactly 2 uops total.
- mask=0x00 → no uop_valid_out; done_out=1 one cycle after start; busy_out stays 0.
- SM, mask=0x03 (R6,R7), base=0xFFFE → (R6,0xFFFE), (R7,0x0000); wrap without error.
- LM, mask=0xF0, flush_in on the 2nd uop cycle → uop_valid_out=0 next cycle, no further uops, no done_out; a new start 1 cycle later is accepted normally. Async rst mid-RUN → all outputs 0 immediately.
